// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-to-device transmitter.
//   - ps2_state_e : transmitter FSM states
//   - CMD_* / RSP_* : common keyboard command and response bytes
//   - odd_parity  : parity bit that makes the 9-bit {parity, data} word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    BITS    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Odd parity: 1 when the data byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-side handshake of the PS/2 host transmitter.
//   tx_data  : byte to send (master -> slave)
//   tx_valid : send request (master -> slave)
//   tx_ready : transmitter idle, byte accepted when tx_valid & tx_ready
//   busy     : inverse of tx_ready
//   done_ok  : one-cycle pulse, device acknowledged the byte
//   done_err : one-cycle pulse, device NAK (or timeout when enabled)
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done_ok;
  logic       done_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done_ok, done_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done_ok, done_err
  );
endinterface

// File: rtl/ps2_sync.sv
// ps2_sync: two-flop synchronizer for one raw PS/2 line plus falling-edge
// detection on the synchronized value.
//   clk  : system clock
//   rst  : synchronous active-high reset, flops return to the idle-high level
//   din  : raw asynchronous line
//   sync : synchronized line level
//   fall : high for one cycle when sync went 1 -> 0 between consecutive cycles
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Two synchronizing flops followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// Sequence: hold clock low (inhibit), pull data low (request-to-send),
// release clock, then shift start/data/parity/stop on the device's falling
// clock edges, read the device ack bit and wait for both lines to go idle.
//
// Ports
//   clk14      : 14 MHz system clock, all logic on its rising edge
//   rst        : synchronous active-high reset
//   host       : ps2_host_tx_if.slave (tx_data, tx_valid, tx_ready, busy,
//                done_ok, done_err)
//   ps2_clk_i  : raw PS/2 clock line (asynchronous)
//   ps2_dat_i  : raw PS/2 data line (asynchronous)
//   ps2_clk_oe : 1 pulls the clock line low, 0 releases it
//   ps2_dat_oe : 1 pulls the data line low, 0 releases it
//
// Build option
//   PS2_TX_TIMEOUT_EN : when defined, a wait longer than TIMEOUT_CYCLES for
//                       any device clock falling edge in BITS/ACK aborts the
//                       transfer with done_err and released lines.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1400,
  parameter int START_CYCLES   = 14,
  parameter int TIMEOUT_CYCLES = 210000
) (
  input  logic               clk14,
  input  logic               rst,
  ps2_host_tx_if.slave       host,
  input  logic               ps2_clk_i,
  input  logic               ps2_dat_i,
  output logic               ps2_clk_oe,
  output logic               ps2_dat_oe
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
`ifdef PS2_TX_TIMEOUT_EN
  // The phase counter doubles as the edge-timeout counter in BITS/ACK.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > PHASE_MAX) ? TIMEOUT_CYCLES : PHASE_MAX;
`else
  localparam int CNT_MAX = PHASE_MAX;
  // Timeouts are compiled out; the parameter stays for a uniform interface.
  localparam int timeout_unused_c = TIMEOUT_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  // Synchronized line levels and edge strobes
  logic clk_sync_s;
  logic clk_fall_s;
  logic dat_sync_s;
  logic dat_fall_unused_s;

  // State and registered outputs
  ps2_state_e       state_r,     state_nxt_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
  logic [3:0]       bit_cnt_r,   bit_cnt_nxt_s;
  logic [7:0]       data_r,      data_nxt_s;
  logic             par_r,       par_nxt_s;
  logic             clk_oe_r,    clk_oe_nxt_s;
  logic             dat_oe_r,    dat_oe_nxt_s;
  logic             tx_ready_r,  tx_ready_nxt_s;
  logic             busy_r,      busy_nxt_s;
  logic             done_ok_r,   done_ok_nxt_s;
  logic             done_err_r,  done_err_nxt_s;

  ps2_sync u_clk_sync (
    .clk  (clk14),
    .rst  (rst),
    .din  (ps2_clk_i),
    .sync (clk_sync_s),
    .fall (clk_fall_s)
  );

  ps2_sync u_dat_sync (
    .clk  (clk14),
    .rst  (rst),
    .din  (ps2_dat_i),
    .sync (dat_sync_s),
    .fall (dat_fall_unused_s)
  );

  // State register and registered outputs.
  always_ff @(posedge clk14) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= 4'd0;
      data_r     <= 8'h00;
      par_r      <= 1'b0;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_ok_r  <= 1'b0;
      done_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      data_r     <= data_nxt_s;
      par_r      <= par_nxt_s;
      clk_oe_r   <= clk_oe_nxt_s;
      dat_oe_r   <= dat_oe_nxt_s;
      tx_ready_r <= tx_ready_nxt_s;
      busy_r     <= busy_nxt_s;
      done_ok_r  <= done_ok_nxt_s;
      done_err_r <= done_err_nxt_s;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every line change appears on a register boundary.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    data_nxt_s     = data_r;
    par_nxt_s      = par_r;
    clk_oe_nxt_s   = clk_oe_r;
    dat_oe_nxt_s   = dat_oe_r;
    tx_ready_nxt_s = tx_ready_r;
    busy_nxt_s     = busy_r;
    done_ok_nxt_s  = 1'b0;
    done_err_nxt_s = 1'b0;

    case (state_r)
      IDLE: begin
        clk_oe_nxt_s = 1'b0;
        dat_oe_nxt_s = 1'b0;
        if (host.tx_valid && tx_ready_r) begin
          data_nxt_s     = host.tx_data;
          par_nxt_s      = odd_parity(host.tx_data);
          cnt_nxt_s      = '0;
          clk_oe_nxt_s   = 1'b1;
          tx_ready_nxt_s = 1'b0;
          busy_nxt_s     = 1'b1;
          state_nxt_s    = INHIBIT;
        end else begin
          tx_ready_nxt_s = 1'b1;
          busy_nxt_s     = 1'b0;
        end
      end

      // Device clock edges are ignored here: the host owns the clock line.
      INHIBIT: begin
        if (cnt_r == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_nxt_s    = '0;
          dat_oe_nxt_s = 1'b1;
          state_nxt_s  = START;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      START: begin
        if (cnt_r == CNT_W'(START_CYCLES - 1)) begin
          cnt_nxt_s     = '0;
          bit_cnt_nxt_s = 4'd0;
          clk_oe_nxt_s  = 1'b0;
          dat_oe_nxt_s  = 1'b1;
          state_nxt_s   = BITS;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      // bit_cnt_r counts falling edges already seen; edge n drives the bit
      // the device samples on the following rising edge.
      BITS: begin
        if (clk_fall_s) begin
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r < 4'd8) begin
            dat_oe_nxt_s = ~data_r[bit_cnt_r[2:0]];
          end else if (bit_cnt_r == 4'd8) begin
            dat_oe_nxt_s = ~par_r;
          end else begin
            dat_oe_nxt_s = 1'b0;
            state_nxt_s  = ACK;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end

      ACK: begin
        if (clk_fall_s) begin
          if (dat_sync_s) begin
            done_err_nxt_s = 1'b1;
          end else begin
            done_ok_nxt_s = 1'b1;
          end
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = ACK;
        end
      end

      RELEASE: begin
        if (clk_sync_s && dat_sync_s) begin
          tx_ready_nxt_s = 1'b1;
          busy_nxt_s     = 1'b0;
          state_nxt_s    = IDLE;
        end else begin
          state_nxt_s = RELEASE;
        end
      end

      default: begin
        clk_oe_nxt_s   = 1'b0;
        dat_oe_nxt_s   = 1'b0;
        tx_ready_nxt_s = 1'b1;
        busy_nxt_s     = 1'b0;
        state_nxt_s    = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Edge watchdog: restarts on every device falling edge, otherwise counts.
    if ((state_r == BITS) || (state_r == ACK)) begin
      if (clk_fall_s) begin
        cnt_nxt_s = '0;
      end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_nxt_s      = '0;
        clk_oe_nxt_s   = 1'b0;
        dat_oe_nxt_s   = 1'b0;
        done_ok_nxt_s  = 1'b0;
        done_err_nxt_s = 1'b1;
        tx_ready_nxt_s = 1'b1;
        busy_nxt_s     = 1'b0;
        state_nxt_s    = IDLE;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
`endif
  end

  assign ps2_clk_oe    = clk_oe_r;
  assign ps2_dat_oe    = dat_oe_r;
  assign host.tx_ready = tx_ready_r;
  assign host.busy     = busy_r;
  assign host.done_ok  = done_ok_r;
  assign host.done_err = done_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-collector
// device model that clocks the bus and acks or NAKs each byte.
// Build option PS2_TX_TIMEOUT_EN adds the edge-timeout sequence.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 1400;
  localparam int STC  = 14;
  localparam int TOC  = 1000;
  localparam int HALF = 40;

  logic clk14 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk14 = ~clk14;

  ps2_host_tx_if host ();

  logic ps2_clk_oe;
  logic ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_line;
  logic ps2_dat_line;

  // Wired-AND open-collector bus.
  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk14      (clk14),
    .rst        (rst),
    .host       (host),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_dat_i  (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int checks = 0;
  int errors = 0;

  // Running totals of done pulses and of cycles with both pulses high.
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge clk14) cyc <= cyc + 1;

  always @(negedge clk14) begin
    if (host.done_ok) ok_cnt <= ok_cnt + 1;
    if (host.done_err) err_cnt <= err_cnt + 1;
    if (host.done_ok && host.done_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request a byte and verify the inhibit / request-to-send timing cycle by cycle.
  task automatic send_and_check_phases(input logic [7:0] d, input bit noise);
    int bad;
    bad = 0;
    @(negedge clk14);
    host.tx_data  = d;
    host.tx_valid = 1'b1;
    @(negedge clk14);
    if (noise) begin
      host.tx_data  = ~d;
      host.tx_valid = 1'b1;
    end else begin
      host.tx_valid = 1'b0;
    end
    for (int i = 0; i < INH + STC + 1; i++) begin
      if (i > 0) @(negedge clk14);
      if (i < INH) begin
        if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) bad++;
      end else if (i < INH + STC) begin
        if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) bad++;
      end else begin
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) bad++;
      end
      if (host.tx_ready !== 1'b0 || host.busy !== 1'b1) bad++;
    end
    host.tx_valid = 1'b0;
    check($sformatf("phase_timing_%02h", d), bad, 0);
    check($sformatf("start_bit_%02h", d), {31'd0, ps2_dat_line}, 0);
  endtask

  // Device model: n clock pulses, data sampled just after each rising edge.
  task automatic dev_clock(input int n, input bit ack, output logic [10:0] smp);
    smp = 11'h7FF;
    for (int k = 1; k <= n; k++) begin
      repeat (HALF) @(negedge clk14);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk14);
      dev_clk_low = 1'b0;
      repeat (2) @(negedge clk14);
      smp[k-1] = ps2_dat_line;
      if (k == 10 && ack) dev_dat_low = 1'b1;
    end
    if (n == 11) begin
      repeat (HALF) @(negedge clk14);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && host.tx_ready !== 1'b1; i++) @(negedge clk14);
    check(name, {31'd0, host.tx_ready}, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         noise;
    logic [9:0] exp_bits;  // {stop, parity, d7..d0} as seen by the device
    int         exp_ok;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] smp;
    int ok0, err0, waited;

    host.tx_data  = 8'h00;
    host.tx_valid = 1'b0;

    vecs[0] = '{CMD_SET_LEDS, 1'b1, 1'b0, 10'b11_1110_1101, 1, 0};
    vecs[1] = '{8'h01,        1'b1, 1'b1, 10'b10_0000_0001, 1, 0};
    vecs[2] = '{8'h00,        1'b1, 1'b0, 10'b11_0000_0000, 1, 0};
    vecs[3] = '{CMD_RESET,    1'b0, 1'b0, 10'b11_1111_1111, 0, 1};
    vecs[4] = '{RSP_ACK,      1'b1, 1'b0, 10'b11_1111_1010, 1, 0};
    vecs[5] = '{8'h80,        1'b0, 1'b1, 10'b10_1000_0000, 0, 1};

    // Reset state
    repeat (5) @(negedge clk14);
    check("rst_tx_ready", {31'd0, host.tx_ready}, 1);
    check("rst_busy",     {31'd0, host.busy}, 0);
    check("rst_clk_oe",   {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe",   {31'd0, ps2_dat_oe}, 0);
    check("rst_done_ok",  {31'd0, host.done_ok}, 0);
    check("rst_done_err", {31'd0, host.done_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk14);

    // Reset abort after the fifth device edge
    ok0 = ok_cnt; err0 = err_cnt;
    send_and_check_phases(8'hA5, 1'b0);
    dev_clock(5, 1'b0, smp);
    check("abort_bits_lo", {27'd0, smp[4:0]}, 5'b00101);
    rst = 1'b1;
    @(negedge clk14);
    rst = 1'b0;
    check("abort_clk_oe",   {31'd0, ps2_clk_oe}, 0);
    check("abort_dat_oe",   {31'd0, ps2_dat_oe}, 0);
    check("abort_tx_ready", {31'd0, host.tx_ready}, 1);
    check("abort_busy",     {31'd0, host.busy}, 0);
    repeat (20) @(negedge clk14);
    check("abort_no_pulse", ok_cnt - ok0 + err_cnt - err0, 0);

    // Table-driven full transfers
    for (int v = 0; v < 6; v++) begin
      ok0 = ok_cnt; err0 = err_cnt;
      send_and_check_phases(vecs[v].data, vecs[v].noise);
      dev_clock(11, vecs[v].ack, smp);
      wait_idle($sformatf("idle_%02h", vecs[v].data));
      repeat (2) @(negedge clk14);
      check($sformatf("line_bits_%02h", vecs[v].data), {22'd0, smp[9:0]}, {22'd0, vecs[v].exp_bits});
      check($sformatf("ack_line_%02h", vecs[v].data), {31'd0, smp[10]}, {31'd0, ~vecs[v].ack});
      check($sformatf("done_ok_%02h", vecs[v].data), ok_cnt - ok0, vecs[v].exp_ok);
      check($sformatf("done_err_%02h", vecs[v].data), err_cnt - err0, vecs[v].exp_err);
      check($sformatf("released_%02h", vecs[v].data), {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Device stalls after the third edge
    ok0 = ok_cnt; err0 = err_cnt;
    send_and_check_phases(8'h3C, 1'b0);
    dev_clock(3, 1'b0, smp);
    waited = 0;
    while (host.done_err !== 1'b1 && waited < 3 * TOC) begin
      @(negedge clk14);
      waited++;
    end
    check("timeout_window", {31'd0, (cyc - last_fall_cyc >= TOC) && (cyc - last_fall_cyc <= TOC + 6)}, 1);
    @(negedge clk14);
    check("timeout_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("timeout_tx_ready", {31'd0, host.tx_ready}, 1);
    check("timeout_err_cnt", err_cnt - err0, 1);
    check("timeout_ok_cnt", ok_cnt - ok0, 0);
`else
    waited = 0;
`endif

    check("never_both_pulses", both_cnt, waited * 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 1400, clock-low inhibit length in clk14 cycles (100 us).
REQ-002 SHALL have parameter START_CYCLES, default 14, data-low-with-clock-low hold in cycles before the clock is released.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 210000, limit on the wait for any single device-clock falling edge (15 ms).
REQ-004 SHALL have port clk14 input 1, the single clock (14 MHz master); all logic on its rising edge.
REQ-005 SHALL have port rst input 1, reset, synchronous and active-high.
REQ-006 SHALL have port tx_data input 8, command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid input 1, request to send tx_data.
REQ-008 SHALL have port tx_ready output 1, high only in IDLE; the byte is accepted on a cycle where tx_valid & tx_ready.
REQ-009 SHALL have port ps2_clk_i input 1, raw PS/2 clock line (asynchronous).
REQ-010 SHALL have port ps2_dat_i input 1, raw PS/2 data line (asynchronous).
REQ-011 SHALL have port ps2_clk_oe output 1; 1 drives the clock line low, 0 releases it (open collector).
REQ-012 SHALL have port ps2_dat_oe output 1; 1 drives the data line low, 0 releases it.
REQ-013 SHALL have port busy output 1, equal to ~tx_ready.
REQ-014 SHALL have port done_ok output 1, a one-cycle pulse when the device acknowledged.
REQ-015 SHALL have port done_err output 1, a one-cycle pulse on NAK, or on timeout when timeouts are enabled.

Function
REQ-016 SHALL pass ps2_clk_i and ps2_dat_i through 2-flop synchronizers; a falling edge is sync_clk 1->0 between consecutive cycles.
REQ-017 SHALL use states IDLE, INHIBIT, START, BITS, ACK, RELEASE.
REQ-018 IDLE: both oe low; on accept, latch tx_data, compute odd parity (~^tx_data) and go to INHIBIT.
REQ-019 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-020 START: clk_oe=1, dat_oe=1 for START_CYCLES cycles, then go to BITS with clk_oe=0 and dat_oe=1 (start bit).
REQ-021 BITS: falling edges 1-8 set dat_oe=~data[n-1] (LSB first); edge 9 sets dat_oe=~parity; edge 10 sets dat_oe=0 (stop bit); after edge 10 go to ACK.
REQ-022 dat_oe SHALL change the cycle after the synchronized falling edge is detected, never at any other time in BITS.
REQ-023 ACK: on the next falling edge sample sync_dat; 0 pulses done_ok and 1 pulses done_err; then go to RELEASE.
REQ-024 RELEASE: wait until sync_clk and sync_dat are both 1, then go to IDLE; tx_ready rises on that transition.
REQ-025 tx_valid while busy SHALL be ignored; the latched byte SHALL NOT change mid-transfer.
REQ-026 done_ok and done_err SHALL never assert in the same cycle; exactly one pulse per accepted byte (no pulse on reset abort).
REQ-027 A falling edge seen in INHIBIT or START SHALL be ignored.

Reset
REQ-028 On rst: state IDLE, tx_ready=1, busy=0, ps2_clk_oe=0, ps2_dat_oe=0, done_ok=0, done_err=0, counters and synchronizers cleared to idle-high.
REQ-029 rst mid-transfer SHALL release both lines on the next cycle and abandon the byte silently.

Configuration
REQ-030 With PS2_TX_TIMEOUT_EN defined: in BITS/ACK, a counter reset on each falling edge reaching TIMEOUT_CYCLES releases both lines, pulses done_err and goes to IDLE.
REQ-031 Without PS2_TX_TIMEOUT_EN: no timeout counter; the FSM waits indefinitely for device edges.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum and command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RSP_ACK=8'hFA).
REQ-033 Sub-module ps2_sync SHALL implement the 2-flop synchronizer and falling-edge detect, instantiated for clock and data.

Verification
REQ-034 tx_data=8'hED accepted; device model clocks 11 edges and acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done_ok one pulse.
REQ-035 tx_data=8'h01 -> parity bit 0 on the line; tx_data=8'h00 -> parity bit 1.
REQ-036 Accept byte -> ps2_clk_oe high for exactly 1400 cycles, then 14 cycles with both oe high, then clk_oe 0 and dat_oe 1.
REQ-037 Device leaves data high at edge 11 -> done_err pulse, done_ok stays 0, returns to IDLE after both lines are high.
REQ-038 rst asserted after edge 5 -> next cycle both oe 0, tx_ready 1, no done pulse; a new byte then transfers correctly.
REQ-039 PS2_TX_TIMEOUT_EN defined with TIMEOUT_CYCLES=1000, device stops after edge 3 -> done_err 1000 cycles after edge 3, lines released.
